// File: rtl/interval_sequencer.sv
// interval_sequencer
//   Walks a small table of phase durations, issuing one registered load
//   strobe per phase to a countdown timer and advancing on the timer's
//   terminal count. Optionally wraps back to phase 0 after the last phase.
//
// Ports
//   clk        : clock, all logic on posedge
//   rst_n      : asynchronous active-low reset (clears outputs and table)
//   cfg_we     : duration table write strobe (honoured only while idle)
//   cfg_addr   : table index for a write
//   cfg_data   : duration value for a write
//   repeat_en  : 1 = wrap to phase 0 after the last phase, 0 = stop there
//   start      : begin a sequence (acted on only while idle)
//   stop       : abort the sequence, highest priority
//   tc         : terminal count from the countdown timer
//   load       : timer load strobe (registered)
//   data_load  : timer load value (registered)
//   phase      : current phase index (registered)
//   busy       : high whenever the sequencer is not idle
//   done       : one-cycle pulse when a non-repeating sequence completes
module interval_sequencer #(
  parameter  int NPHASE = 4,
  parameter  int WIDTH  = 10,
  localparam int PW     = $clog2(NPHASE)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_we,
  input  logic [PW-1:0]    cfg_addr,
  input  logic [WIDTH-1:0] cfg_data,
  input  logic             repeat_en,
  input  logic             start,
  input  logic             stop,
  input  logic             tc,
  output logic             load,
  output logic [WIDTH-1:0] data_load,
  output logic [PW-1:0]    phase,
  output logic             busy,
  output logic             done
);

  localparam logic [PW-1:0] LAST = PW'(NPHASE - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    phase_q, phase_d;
  logic             load_q, load_d;
  logic [WIDTH-1:0] data_load_q, data_load_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             seq_end;
  logic [WIDTH-1:0] dur_q [NPHASE];
  logic [WIDTH-1:0] dur_d [NPHASE];

  // State register and all output/table flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      phase_q     <= '0;
      load_q      <= 1'b0;
      data_load_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      for (int i = 0; i < NPHASE; i++) dur_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      load_q      <= load_d;
      data_load_q <= data_load_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      for (int i = 0; i < NPHASE; i++) dur_q[i] <= dur_d[i];
    end
  end

  // Table writes are accepted only while idle; indices past the table
  // (possible when NPHASE is not a power of two) are ignored.
  always_comb begin
    dur_d = dur_q;
    if (cfg_we && (state_q == S_IDLE) && (int'(cfg_addr) < NPHASE))
      dur_d[cfg_addr] = cfg_data;
  end

  // Next-state logic. stop overrides everything and leaves phase untouched.
  // tc is deliberately ignored in LOAD: it can still be high from the
  // interval that just ended.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    seq_end = 1'b0;
    if (stop) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d = S_LOAD;
            phase_d = '0;
          end
        end
        S_LOAD: state_d = S_WAIT;
        S_WAIT: begin
          if (tc) begin
            if (phase_q != LAST) begin
              phase_d = phase_q + 1'b1;
              state_d = S_LOAD;
            end else if (repeat_en) begin
              phase_d = '0;
              state_d = S_LOAD;
            end else begin
              state_d = S_IDLE;
              seq_end = 1'b1;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Outputs are registered from the next state so that load/data_load are
  // visible during the LOAD cycle itself and busy rises on the entering edge.
  always_comb begin
    load_d      = (state_d == S_LOAD);
    data_load_d = load_d ? dur_q[phase_d] : data_load_q;
    busy_d      = (state_d != S_IDLE);
    done_d      = seq_end;
  end

  assign load      = load_q;
  assign data_load = data_load_q;
  assign phase     = phase_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_interval_sequencer.sv
module tb_interval_sequencer;

  localparam int NPHASE = 4;
  localparam int WIDTH  = 10;
  localparam int PW     = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cfg_we = 1'b0;
  logic [PW-1:0]    cfg_addr = '0;
  logic [WIDTH-1:0] cfg_data = '0;
  logic             repeat_en = 1'b0;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic             tc;
  logic             load;
  logic [WIDTH-1:0] data_load;
  logic [PW-1:0]    phase;
  logic             busy;
  logic             done;

  int nassert = 0;
  int nfail   = 0;

  // Reference view of the duration table and of the last loaded phase.
  int tbl [NPHASE];
  int last_data  = 0;
  int last_phase = 0;

  // Countdown timer model: tc rises D cycles after capturing a load of D
  // and stays high until the next load.
  logic [WIDTH-1:0] tcnt;
  logic             armed;

  interval_sequencer #(.NPHASE(NPHASE), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .repeat_en(repeat_en), .start(start), .stop(stop),
    .tc(tc), .load(load), .data_load(data_load), .phase(phase),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed <= 1'b0;
      tcnt  <= '0;
    end else if (load) begin
      armed <= 1'b1;
      tcnt  <= data_load;
    end else if (armed && tcnt != 0) begin
      tcnt <= tcnt - 1'b1;
    end
  end
  assign tc = armed && (tcnt == 0);

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance one clock, sample 1 time unit after the edge, drop one-shot inputs.
  task automatic step();
    @(posedge clk);
    #1;
    start  = 1'b0;
    stop   = 1'b0;
    cfg_we = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nassert++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_cycle(input string tag, input logic l, input int dl, input int ph,
                             input logic b, input logic dn);
    check($sformatf("%s.load", tag), 32'(load), 32'(l));
    check($sformatf("%s.data_load", tag), 32'(data_load), dl);
    check($sformatf("%s.phase", tag), 32'(phase), ph);
    check($sformatf("%s.busy", tag), 32'(busy), 32'(b));
    check($sformatf("%s.done", tag), 32'(done), 32'(dn));
  endtask

  task automatic cfg_write(input int a, input int v);
    cfg_we   = 1'b1;
    cfg_addr = PW'(a);
    cfg_data = WIDTH'(v);
    step();
    tbl[a] = v;
  endtask

  // Start a sequence and check every cycle against the phase-timing rules:
  // each phase shows load for one cycle, then D+1 wait cycles, so loads are
  // D+2 apart. Optionally stop at wait index stop_i of stop_phase (index 0
  // is the load cycle), and optionally attempt a table write while busy.
  task automatic expect_run(input int passes, input int stop_phase, input int stop_i,
                            input bit cfg_busy);
    int d;
    start = 1'b1;
    step();
    for (int ps = 0; ps < passes; ps++) begin
      for (int p = 0; p < NPHASE; p++) begin
        d = tbl[p];
        repeat_en  = (ps < passes - 1);
        last_data  = d;
        last_phase = p;
        check_cycle("load", 1'b1, d, p, 1'b1, 1'b0);
        if (cfg_busy && ps == 0 && p == 0) begin
          cfg_we   = 1'b1;
          cfg_addr = PW'(1);
          cfg_data = WIDTH'(9);
        end
        for (int i = 0; i <= d + 1; i++) begin
          if (i > 0) check_cycle("wait", 1'b0, d, p, 1'b1, 1'b0);
          if (ps == 0 && p == stop_phase && i == stop_i) begin
            stop = 1'b1;
            step();
            check_cycle("stop", 1'b0, d, p, 1'b0, 1'b0);
            step();
            check_cycle("stop_idle", 1'b0, d, p, 1'b0, 1'b0);
            return;
          end
          step();
        end
      end
    end
    check_cycle("done", 1'b0, last_data, last_phase, 1'b0, 1'b1);
    step();
    check_cycle("idle", 1'b0, last_data, last_phase, 1'b0, 1'b0);
  endtask

  initial begin
    int sp, si, np;
    for (int i = 0; i < NPHASE; i++) tbl[i] = 0;

    // Reset state
    repeat (2) step();
    check_cycle("reset", 1'b0, 0, 0, 1'b0, 1'b0);
    rst_n = 1'b1;
    step();

    // Basic sequence: loads 3,0,5,1 spaced 5,2,7; done 3 cycles after last load
    cfg_write(0, 3);
    cfg_write(1, 0);
    cfg_write(2, 5);
    cfg_write(3, 1);
    expect_run(1, -1, -1, 1'b0);

    // Repeat mode: wrap once, repeat_en dropped during the second pass
    expect_run(2, -1, -1, 1'b0);

    // Stop mid-interval in WAIT of phase 2, then restart from phase 0
    expect_run(1, 2, 3, 1'b0);
    expect_run(1, -1, -1, 1'b0);

    // start and stop together while idle: stays idle
    start = 1'b1;
    stop  = 1'b1;
    step();
    check_cycle("start_stop", 1'b0, last_data, last_phase, 1'b0, 1'b0);
    step();
    check_cycle("start_stop2", 1'b0, last_data, last_phase, 1'b0, 1'b0);

    // tc and stop in the same WAIT cycle (last wait cycle of phase 1): no advance
    expect_run(1, 1, tbl[1] + 1, 1'b0);

    // Config while busy is dropped; next pass still loads 0 for phase 1
    expect_run(2, -1, -1, 1'b1);
    // Same write while idle takes effect
    cfg_write(1, 9);
    expect_run(1, -1, -1, 1'b0);

    // Asynchronous reset mid-run
    start = 1'b1;
    step();
    repeat (4) step();
    #2;
    rst_n = 1'b0;
    #1;
    check_cycle("async_reset", 1'b0, 0, 0, 1'b0, 1'b0);
    for (int i = 0; i < NPHASE; i++) tbl[i] = 0;
    last_data  = 0;
    last_phase = 0;
    step();
    rst_n = 1'b1;
    step();
    expect_run(1, -1, -1, 1'b0);

    // Randomized tables, pass counts and stop points
    for (int r = 0; r < 8; r++) begin
      for (int p = 0; p < NPHASE; p++) cfg_write(p, $urandom_range(0, 6));
      if ($urandom_range(0, 2) == 0) begin
        sp = $urandom_range(0, NPHASE - 1);
        si = $urandom_range(0, tbl[sp] + 1);
        expect_run(1, sp, si, 1'b0);
      end else begin
        np = $urandom_range(1, 2);
        expect_run(np, -1, -1, 1'b0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
    $finish;
  end

endmodule

// File: doc/interval_sequencer.md
# interval_sequencer

Control-side partner of the 10-bit countdown timer. It holds a small table of phase durations and, for each phase, sends a one-cycle `load` with that phase's duration. It then waits for the timer's terminal-count `tc` and advances to the next phase. It sits between the register/config path and the countdown timer and drives the timer's `load`/`data_load` inputs directly.

## Interface
- `NPHASE`, 4: number of phases in the table (2..16).
- `WIDTH`, 10: duration width; must match the timer's `data_load` width.
- `PW`, $clog2(NPHASE): phase index width (derived, not overridden).

- `clk`  in  1  single clock, all logic on posedge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `cfg_we`  in  1  duration table write strobe.
- `cfg_addr`  in  PW  table index for write.
- `cfg_data`  in  WIDTH  duration value for write.
- `repeat_en`  in  1  1 = wrap to phase 0 after last phase; 0 = stop after last phase.
- `start`  in  1  begin sequence (sampled level, acted on in IDLE only).
- `stop`  in  1  abort sequence.
- `tc`  in  1  terminal count from countdown timer.
- `load`  out  1  timer load strobe, registered.
- `data_load`  out  WIDTH  timer load value, registered.
- `phase`  out  PW  current phase index, registered.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle pulse when a non-repeating sequence completes.

## Operation
- Duration table `dur[0..NPHASE-1]`, WIDTH bits each, reset to 0.
- The table is writable only in IDLE. A `cfg_we` while `busy` is dropped silently.
- An out-of-range `cfg_addr` (when NPHASE is not a power of 2) is ignored.
- States: IDLE, LOAD, WAIT. State register is one-hot or binary; implementer's choice.
- IDLE:
  - `start`=1 and `stop`=0 -> `phase`<=0, go LOAD.
  - Otherwise stay.
- LOAD:
  - `load`=1 and `data_load`=`dur[phase]` are visible during this state's cycle.
  - Go WAIT unconditionally.
  - `tc` is not sampled in LOAD; it may be stale from the previous interval.
- WAIT:
  - `load`=0; `data_load` holds its last value.
  - `tc`=1 and `phase`<NPHASE-1 -> `phase`+1, go LOAD.
  - `tc`=1, `phase`=NPHASE-1, `repeat_en`=1 -> `phase`<=0, go LOAD.
  - `tc`=1, `phase`=NPHASE-1, `repeat_en`=0 -> `done`=1 for the next cycle, go IDLE.
  - `tc`=0 -> stay.
- `stop`=1 in any state -> IDLE on the next edge, with `load`=0 and no `done` pulse. `phase` holds its value.
- `stop` has priority over `start` and `tc` in the same cycle.
- `start` while `busy` is ignored.
- `repeat_en` is sampled only at the last-phase `tc`.
- A duration of 0 is legal. The timer asserts `tc` right after loading, giving a 2-cycle phase.
- Reset mid-operation forces IDLE immediately (asynchronous) and clears all outputs and the table.

## Timing
- Reset values: `load`=0, `data_load`=0, `phase`=0, `busy`=0, `done`=0.
- Start latency:
  - `start` sampled at edge e0 -> `load`=1 during cycle e0..e0+1.
  - The timer captures the load at edge e0+1.
- Timer contract: the timer's `tc` rises D cycles after the edge at which it captures a load of D.
- Load-to-load period of a phase with duration D is D+2 cycles:
  - `tc` is seen in WAIT one cycle after it rises.
  - The next `load` is registered one cycle after that.
- `done` pulse timing: `done` rises on the edge after the last-phase `tc` is sampled. It lasts exactly 1 cycle, coincident with `busy` falling.
- `load` is never high for two consecutive cycles.
- `busy` goes high on the same edge that enters LOAD from IDLE.

## Test plan
- **Basic sequence.** Write dur={3,0,5,1}, `repeat_en`=0, start, with the countdown timer attached.
  - `load` pulses carry values 3,0,5,1.
  - Pulses are spaced 5,2,7 cycles apart.
  - `done` arrives 3 cycles after the last `load`.
  - `busy`=0 afterwards.
- **Repeat mode.** Same table, `repeat_en`=1.
  - After phase 3, `phase` wraps to 0 and `load`=3 recurs 3 cycles after the phase-3 `load`.
  - No `done` is pulsed.
  - Deassert `repeat_en` during the second pass -> `done` at the end of that pass.
- **Stop mid-interval.** `stop` during WAIT of phase 2.
  - IDLE next cycle, `load`=0, no `done`, `phase`=2.
  - A subsequent `start` restarts at phase 0.
- **Simultaneous events.**
  - `start`+`stop` in the same IDLE cycle -> stays IDLE.
  - `tc`+`stop` in the same WAIT cycle -> IDLE, no advance.
- **Config while busy.** `cfg_we` with addr 1, data 9 during a run.
  - Table is unchanged; the next pass still loads 0 for phase 1.
  - The same write in IDLE takes effect.
- **Asynchronous reset mid-run.** Assert `rst_n`=0 between edges.
  - All outputs are 0 immediately.
  - Table reads back as 0: a start after release loads 0 for every phase, giving 2-cycle spacing.
